button_input_port: RTL and testbench

//  Input-side counterpart of the SoC display port. It turns the board's active-low button pads into a

---
 rtl/btn_pkg.sv | 13 +
 rtl/button_input_port_if.sv | 19 +
 rtl/btn_debounce.sv | 62 ++++++
 rtl/button_input_port.sv | 111 +++++++++++
 tb/tb_button_input_port.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg -- shared constants for the button input port.
//   ADDR_LEVEL / ADDR_EVENT : rd_addr decode values
//   DATA_W                  : read data width
//   MAX_INPUTS              : largest supported pad count; also the bit offset of
//                             the release-event field in the EVENT register
package btn_pkg;

    localparam logic ADDR_LEVEL = 1'b0;
    localparam logic ADDR_EVENT = 1'b1;
    localparam int   DATA_W     = 16;
    localparam int   MAX_INPUTS = 8;

endpackage

// File: rtl/button_input_port_if.sv
// button_input_port_if -- core-side read bus of the button input port.
//   rd_en    : one-cycle read strobe (master -> slave)
//   rd_addr  : 0 = LEVEL, 1 = EVENT (master -> slave)
//   rd_data  : registered read data (slave -> master)
//   rd_valid : one-cycle pulse the cycle after rd_en (slave -> master)
//   irq      : level interrupt, high while any event is pending (slave -> master)
interface button_input_port_if;
    import btn_pkg::*;

    logic              rd_en;
    logic              rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              irq;

    modport master (output rd_en, rd_addr, input rd_data, rd_valid, irq);
    modport slave  (input rd_en, rd_addr, output rd_data, rd_valid, irq);

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce -- synchroniser plus debouncer for one active-low button pad.
//   clk, reset_n : clock, async active-low reset
//   raw_n        : raw pad, asynchronous to clk
//   stable_n     : debounced level (1 = released)
//   fall_p       : one-cycle pulse on the edge where stable_n goes 1->0 (press)
//   rise_p       : one-cycle pulse on the edge where stable_n goes 0->1 (release)
// A change is accepted after the synchronised input has differed from stable_n
// for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n,
    output logic stable_n,
    output logic fall_p,
    output logic rise_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             sync_n;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sync_n = sync_q[1];

    always_comb begin
        sync_d   = {sync_q[0], raw_n};
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_n == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_n;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulses are taken from the next-state so the event latch sets on the
    // same edge that stable_n changes.
    assign fall_p   =  stable_q & ~stable_d;
    assign rise_p   = ~stable_q &  stable_d;
    assign stable_n =  stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/button_input_port.sv
// button_input_port -- memory-mapped, debounced button input register.
//   clk, reset_n : clock, async active-low reset
//   btn_raw_n    : N_INPUTS raw active-low pads
//   bus (slave)  : rd_en/rd_addr in; rd_data/rd_valid/irq out
// LEVEL (addr 0) returns the debounced pressed state. EVENT (addr 1) returns the
// latched press events and clears exactly the returned bits; a new event on the
// clearing edge wins. irq is a registered OR of all pending events.
// Build option BTN_RELEASE_EVT_EN: also latch release events in EVENT[8+i].
module button_input_port
    import btn_pkg::*;
#(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_INPUTS-1:0] btn_raw_n,
    button_input_port_if.slave  bus
);

    logic [N_INPUTS-1:0] stable_vec;
    logic [N_INPUTS-1:0] fall_vec;
    logic [N_INPUTS-1:0] rise_vec;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_n    (btn_raw_n[i]),
            .stable_n (stable_vec[i]),
            .fall_p   (fall_vec[i]),
            .rise_p   (rise_vec[i])
        );
    end

    logic [N_INPUTS-1:0] press_q, press_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                irq_q, irq_d;
    logic                rd_evt;

`ifdef BTN_RELEASE_EVT_EN
    logic [N_INPUTS-1:0] rel_q, rel_d;
`else
    logic unused_rise;
    assign unused_rise = ^rise_vec;
`endif

    assign rd_evt = bus.rd_en && (bus.rd_addr == ADDR_EVENT);

    always_comb begin
        // An EVENT read returns the current bits, so clearing all of them
        // clears exactly what was returned; OR-ing new edges afterwards
        // makes a same-cycle set win.
        press_d = rd_evt ? '0 : press_q;
        press_d = press_d | fall_vec;
`ifdef BTN_RELEASE_EVT_EN
        rel_d   = rd_evt ? '0 : rel_q;
        rel_d   = rel_d | rise_vec;
`endif

        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        if (bus.rd_en) begin
            rd_data_d = '0;
            if (bus.rd_addr == ADDR_LEVEL) begin
                rd_data_d[N_INPUTS-1:0] = ~stable_vec;
            end else begin
                rd_data_d[N_INPUTS-1:0] = press_q;
`ifdef BTN_RELEASE_EVT_EN
                rd_data_d[MAX_INPUTS +: N_INPUTS] = rel_q;
`endif
            end
        end

`ifdef BTN_RELEASE_EVT_EN
        irq_d = (|press_q) | (|rel_q);
`else
        irq_d = |press_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q    <= '0;
`ifdef BTN_RELEASE_EVT_EN
            rel_q      <= '0;
`endif
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            press_q    <= press_d;
`ifdef BTN_RELEASE_EVT_EN
            rel_q      <= rel_d;
`endif
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_button_input_port.sv
// tb_button_input_port -- directed scoreboard bench for button_input_port.
// Every read pushes its expected rd_data; a monitor on the falling edge pops
// one entry per rd_valid cycle. Timing-sensitive checks (irq latency, async
// reset) are made inline. Release-event expectations follow BTN_RELEASE_EVT_EN.
module tb_button_input_port;

    localparam int N   = 4;
    localparam int DEB = 4;
`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_raw_n;

    button_input_port_if bus ();

    button_input_port #(.N_INPUTS(N), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw_n (btn_raw_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Release-event field as the EVENT register should show it.
    function automatic logic [15:0] rel(input logic [7:0] mask);
        return REL ? {mask, 8'h00} : 16'h0000;
    endfunction

    // Monitor: one expected value consumed per rd_valid cycle.
    always @(negedge clk) begin
        if (reset_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_valid_unexpected: got data %h with no read pending at %0t",
                         bus.rd_data, $time);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read sampled on the next rising edge; returns 1 ns after that edge.
    task automatic rd(input logic a, input logic [15:0] e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        exp_q.push_back(e);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        btn_raw_n   = '1;
        bus.rd_en   = 1'b0;
        bus.rd_addr = 1'b0;
        #2;
        chk("reset_rd_data", bus.rd_data, 16'h0);
        chk("reset_rd_valid", {15'h0, bus.rd_valid}, 16'h0);
        chk("reset_irq", {15'h0, bus.irq}, 16'h0);
        repeat (2) @(posedge clk);
        #5 reset_n = 1'b1;
        tick();

        // 1: press btn0; event lands 6 edges after the pad change, irq one later.
        btn_raw_n[0] = 1'b0;
        repeat (6) tick();
        chk("t1_irq_before", {15'h0, bus.irq}, 16'h0);
        tick();
        chk("t1_irq_after", {15'h0, bus.irq}, 16'h1);
        repeat (3) tick();
        rd(1'b0, 16'h0001);
        rd(1'b1, 16'h0001);
        chk("t1_irq_clear_edge", {15'h0, bus.irq}, 16'h1);
        tick();
        chk("t1_irq_cleared", {15'h0, bus.irq}, 16'h0);
        rd(1'b1, 16'h0000);
        btn_raw_n[0] = 1'b1;
        repeat (10) tick();
        rd(1'b1, rel(8'h01));

        // 2: bouncing btn1 never reaches terminal count.
        for (int k = 0; k < 10; k++) begin
            btn_raw_n[1] = ~btn_raw_n[1];
            repeat (2) tick();
        end
        repeat (10) tick();
        rd(1'b0, 16'h0000);
        rd(1'b1, 16'h0000);

        // 3+4: btn2 event sets on the edge that clears bit 0, then a LEVEL burst.
        btn_raw_n[0] = 1'b0;
        repeat (10) tick();
        btn_raw_n[2] = 1'b0;
        repeat (5) tick();
        rd(1'b1, 16'h0001);
        rd(1'b0, 16'h0005);
        rd(1'b0, 16'h0005);
        rd(1'b0, 16'h0005);
        chk("t4_irq_held", {15'h0, bus.irq}, 16'h1);
        rd(1'b1, 16'h0004);
        btn_raw_n[0] = 1'b1;
        btn_raw_n[2] = 1'b1;
        repeat (10) tick();
        rd(1'b1, rel(8'h05));

        // 5: reset while btn3 is mid-debounce, with btn1 held through reset.
        btn_raw_n[1] = 1'b0;
        repeat (10) tick();
        btn_raw_n[3] = 1'b0;
        repeat (2) tick();
        rd(1'b0, 16'h0002);
        tick();
        #1 reset_n = 1'b0;
        #1;
        chk("t5_reset_rd_data", bus.rd_data, 16'h0);
        chk("t5_reset_rd_valid", {15'h0, bus.rd_valid}, 16'h0);
        chk("t5_reset_irq", {15'h0, bus.irq}, 16'h0);
        repeat (3) @(posedge clk);
        #5 reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) tick();
        rd(1'b1, 16'h0000);
        rd(1'b1, 16'h000A);
        btn_raw_n[1] = 1'b1;
        btn_raw_n[3] = 1'b1;
        repeat (10) tick();
        rd(1'b1, rel(8'h0A));

        // 6: press and release btn0.
        btn_raw_n[0] = 1'b0;
        repeat (10) tick();
        btn_raw_n[0] = 1'b1;
        repeat (10) tick();
        rd(1'b1, 16'h0001 | rel(8'h01));

        repeat (3) tick();
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
